mult_issue_ctrl: RTL and testbench



---
 rtl/mult_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl
//   Sequencing stage in front of the radix-8 Booth multiplier. It takes one
//   RV32M multiply request (MUL/MULH/MULHSU/MULHU), drives the multiplier
//   (which always computes signed x signed), waits for MULT_FINISH, applies
//   the unsigned / mixed-sign high-word correction and returns the 32-bit
//   result. Illegal funct3 values and multiplier timeouts give an error
//   response with resp_data = 0.
//
//   Optional feature (macro MULT_ZERO_BYPASS_EN): a legal request with a
//   zero operand skips the multiplier and answers 0 one cycle after it is
//   accepted.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_funct3, req_a, req_b
//   resp_valid/resp_ready response handshake; resp_data, resp_err
//   stall                 high while a request is in flight
//   OPER_A, OPER_B        operands to the multiplier
//   ENABLE_MULT           multiplier enable, held high while waiting
//   FUCT3                 0 = low word, 1 = high word (signed x signed)
//   MULT_O, MULT_FINISH   multiplier result and done strobe

module mult_issue_ctrl #(
    parameter int length  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [length-1:0] req_a,
    input  logic [length-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [length-1:0] resp_data,
    output logic              resp_err,
    output logic              stall,
    output logic [length-1:0] OPER_A,
    output logic [length-1:0] OPER_B,
    output logic              ENABLE_MULT,
    output logic              FUCT3,
    input  logic [length-1:0] MULT_O,
    input  logic              MULT_FINISH
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        funct3_r;
    logic [CW-1:0]     cnt;
    logic [length-1:0] corr;
    logic              zero_op;

    // OPER_A/OPER_B double as the operand registers: they are loaded on
    // acceptance and stay stable until the next request, so the correction
    // below can use them directly.
    //
    // The multiplier returns the signed x signed high word H. Reading an
    // operand as unsigned adds 2^32 * (other operand) when its MSB is set,
    // which only affects the high word by +other (mod 2^32).
    always_comb begin
        corr = MULT_O;
        case (funct3_r)
            3'b010:  corr = MULT_O + (OPER_B[length-1] ? OPER_A : '0);
            3'b011:  corr = MULT_O + (OPER_A[length-1] ? OPER_B : '0)
                                   + (OPER_B[length-1] ? OPER_A : '0);
            default: corr = MULT_O;
        endcase
    end

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (req_a == '0) || (req_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            funct3_r    <= 3'b000;
            cnt         <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            stall       <= 1'b0;
            OPER_A      <= '0;
            OPER_B      <= '0;
            ENABLE_MULT <= 1'b0;
            FUCT3       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        OPER_A    <= req_a;
                        OPER_B    <= req_b;
                        funct3_r  <= req_funct3;
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
                        if (req_funct3[2] || zero_op) begin
                            // Answer without touching the multiplier.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_err   <= req_funct3[2];
                        end else begin
                            state       <= ISSUE;
                            FUCT3       <= (req_funct3 != 3'b000);
                            ENABLE_MULT <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end

                WAIT: begin
                    // A finish on the last allowed cycle beats the timeout.
                    if (MULT_FINISH) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_data   <= corr;
                        resp_err    <= 1'b0;
                        ENABLE_MULT <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        ENABLE_MULT <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        stall      <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl. A behavioural multiplier
// (signed x signed, low or high word) answers ENABLE_MULT after a chosen
// number of WAIT cycles; expected results come from full 64-bit products
// with the RV32M operand signedness of each funct3.

module tb_mult_issue_ctrl;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        stall;
    logic [31:0] OPER_A;
    logic [31:0] OPER_B;
    logic        ENABLE_MULT;
    logic        FUCT3;
    logic [31:0] MULT_O = '0;
    logic        MULT_FINISH = 1'b0;

    int vectors = 0;
    int errors  = 0;

    mult_issue_ctrl #(.length(32), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .stall(stall),
        .OPER_A(OPER_A), .OPER_B(OPER_B), .ENABLE_MULT(ENABLE_MULT),
        .FUCT3(FUCT3), .MULT_O(MULT_O), .MULT_FINISH(MULT_FINISH)
    );

    always #5 CLK = ~CLK;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // What the Booth multiplier itself produces: always signed x signed.
    function automatic logic [31:0] mult_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // Architectural RV32M result.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        case (f3)
            3'b001:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b010:  p = {{32{a[31]}}, a} * {32'd0, b};
            3'b011:  p = {32'd0, a} * {32'd0, b};
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit is_bypass(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        return !f3[2] && (a == 0 || b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // fin: WAIT cycles before MULT_FINISH (>= TIMEOUT means never).
    // hold: cycles resp_ready stays low once resp_valid is up.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int fin, input int hold);
        bit          nomult;
        bit          exp_err;
        int          exp_lat;
        int          c;
        logic [31:0] exp_data;
        logic [31:0] seen;

        nomult   = f3[2] || is_bypass(f3, a, b);
        exp_err  = f3[2] || (!nomult && fin >= TIMEOUT);
        exp_lat  = nomult ? 1 : (fin < TIMEOUT ? 3 + fin : 2 + TIMEOUT);
        exp_data = exp_err ? 32'd0 : (is_bypass(f3, a, b) ? 32'd0 : ref_result(f3, a, b));

        @(negedge CLK);
        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_stall", stall, 1'b0);
        req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b;
        c = 0;
        forever begin
            @(negedge CLK);
            c++;
            req_valid = 1'b0;
            req_a = $urandom; req_b = $urandom;
            MULT_FINISH = 1'b0;
            if (resp_valid) break;
            if (c > 40) begin
                chk1("resp_timeout", 1'b0, 1'b1);
                break;
            end
            chk1("busy_stall", stall, 1'b1);
            chk1("busy_req_ready", req_ready, 1'b0);
            chk1("busy_enable", ENABLE_MULT, !nomult);
            if (c == 1) begin
                chk32("oper_a", OPER_A, a);
                chk32("oper_b", OPER_B, b);
                chk1("fuct3", FUCT3, f3 != 3'b000);
                // Noise during ISSUE must be ignored.
                MULT_FINISH = 1'($urandom_range(0, 1));
                MULT_O = $urandom;
            end else if (c == 2 + fin) begin
                MULT_FINISH = 1'b1;
                MULT_O = mult_model(f3, a, b);
            end else begin
                MULT_O = $urandom;
            end
        end
        chk32("latency", 32'(c), 32'(exp_lat));
        chk32("resp_data", resp_data, exp_data);
        chk1("resp_err", resp_err, exp_err);
        seen = resp_data;
        for (int r = 0; r < hold; r++) begin
            resp_ready = 1'b0;
            MULT_FINISH = 1'($urandom_range(0, 1));
            MULT_O = $urandom;
            @(negedge CLK);
            chk1("hold_valid", resp_valid, 1'b1);
            chk32("hold_data", resp_data, seen);
            chk1("hold_req_ready", req_ready, 1'b0);
            chk1("hold_enable", ENABLE_MULT, 1'b0);
        end
        MULT_FINISH = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        chk1("done_valid", resp_valid, 1'b0);
        chk1("done_req_ready", req_ready, 1'b1);
        chk1("done_stall", stall, 1'b0);
    endtask

    initial begin
        logic [31:0] corner [4];
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        corner[0] = 32'h0000_0000; corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h7FFF_FFFF;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_resp_data", resp_data, 32'd0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk32("rst_oper_a", OPER_A, 32'd0);
        chk32("rst_oper_b", OPER_B, 32'd0);
        chk1("rst_enable", ENABLE_MULT, 1'b0);
        chk1("rst_fuct3", FUCT3, 1'b0);
        RST = 1'b0;

        // Directed cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0);            // MUL 7 * -3
        chk32("mul_7_m3", resp_data, 32'hFFFF_FFEB);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);    // MULHU
        chk32("mulhu_max", resp_data, 32'hFFFF_FFFE);
        run_op(3'b010, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);    // MULHSU
        chk32("mulhsu", resp_data, 32'hFFFF_FFFF);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 2, 1);    // MULH
        run_op(3'b100, 32'd5, 32'd6, 0, 0);                    // illegal
        run_op(3'b111, 32'd5, 32'd6, 0, 2);                    // illegal
        run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, TIMEOUT, 0);     // timeout
        run_op(3'b011, 32'hDEAD_BEEF, 32'hCAFE_F00D, TIMEOUT - 1, 0); // finish wins
        run_op(3'b000, 32'd3, 32'd9, 0, 5);                    // resp_ready low 5 cycles
        run_op(3'b000, 32'd0, 32'd5, 0, 0);                    // zero operand
        run_op(3'b011, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Reset pulsed while waiting on the multiplier
        @(negedge CLK);
        req_valid = 1'b1; req_funct3 = 3'b001; req_a = 32'd11; req_b = 32'd13;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk1("midwait_enable", ENABLE_MULT, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk1("arst_enable", ENABLE_MULT, 1'b0);
        chk1("arst_stall", stall, 1'b0);
        chk1("arst_req_ready", req_ready, 1'b1);
        chk1("arst_resp_valid", resp_valid, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(3'b001, 32'd11, 32'd13, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            rf = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3))
                                             : 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            run_op(rf, ra, rb,
                   ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 5),
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
